// File: rtl/hazard_pkg.sv
// Shared types for the RV32I data-hazard controller: forwarding selects and the
// per-stage destination-register record kept by the shadow pipeline.
package hazard_pkg;

  // Widest register address a record can hold; narrower ids are zero-extended.
  localparam int REC_RD_W = 8;

  localparam logic [REC_RD_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } hz_rec_t;

  // A record can only cause a hazard if it really writes a non-x0 register.
  function automatic logic is_source(hz_rec_t r);
    return r.valid && r.regwrite && (r.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_rec_reg.sv
// One stage of the shadow pipeline: a destination-register record with
// asynchronous clear and a synchronous load-invalid (bubble) input.
module hazard_rec_reg
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    kill,
  input  hz_rec_t d,
  output hz_rec_t q
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value, giving a true shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// RAW hazard detection for the ID instruction against the EX/MEM/WB shadow
// records: stall/bubble/flush control, registered forwarding selects, stall counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_count
);

  hz_rec_t          id_rec, ex_q, mem_q, wb_q;
  logic             ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic             hazard;
  fwd_sel_e         sel_a, sel_b, fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic src_match(logic v, logic use_s, logic [REG_AW-1:0] rs,
                                     hz_rec_t r);
    return v && use_s && is_source(r) && (r.rd == REC_RD_W'(rs));
  endfunction

  // Nearer stage wins; a load in EX has no value yet, so it is left to the stall.
  function automatic fwd_sel_e pick(logic m_ex, logic ex_load, logic m_mem);
    if (m_ex && !ex_load) return FWD_MEM;
    if (m_mem)            return FWD_WB;
    return FWD_RF;
  endfunction

  assign id_rec = '{valid: id_valid, rd: REC_RD_W'(id_rd),
                    regwrite: id_regwrite, is_load: id_is_load};

  assign ex_a  = src_match(id_valid, id_use_rs1, id_rs1, ex_q);
  assign ex_b  = src_match(id_valid, id_use_rs2, id_rs2, ex_q);
  assign mem_a = src_match(id_valid, id_use_rs1, id_rs1, mem_q);
  assign mem_b = src_match(id_valid, id_use_rs2, id_rs2, mem_q);
  assign wb_a  = src_match(id_valid, id_use_rs1, id_rs1, wb_q);
  assign wb_b  = src_match(id_valid, id_use_rs2, id_rs2, wb_q);

  always_comb begin
    // NOTE: defaults first on every path keep this block free of inferred latches.
    hazard = 1'b0;
    sel_a  = FWD_RF;
    sel_b  = FWD_RF;
    if (FWD_EN) begin
      hazard = (ex_a || ex_b) && ex_q.is_load;
      sel_a  = pick(ex_a, ex_q.is_load, mem_a);
      sel_b  = pick(ex_b, ex_q.is_load, mem_b);
    end else begin
      hazard = ex_a || ex_b || mem_a || mem_b || wb_a || wb_b;
    end
  end

  // A flushed ID instruction is squashed, so it must not also hold the front end.
  assign stall       = hazard && !flush;
  assign bubble      = stall || flush;
  assign flush_if_id = flush;

  hazard_rec_reg u_ex  (.clk(clk), .reset(reset), .kill(bubble), .d(id_rec), .q(ex_q));
  hazard_rec_reg u_mem (.clk(clk), .reset(reset), .kill(1'b0),   .d(ex_q),   .q(mem_q));
  hazard_rec_reg u_wb  (.clk(clk), .reset(reset), .kill(1'b0),   .d(mem_q),  .q(wb_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (bubble) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= sel_a;
      fwd_b_q <= sel_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (stall && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: forwarding, interlock and saturating
// counter instances driven from a shared instruction stream.
module tb_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } ins_t;

  typedef struct {
    bit         fe;
    ins_t       prod;
    int         gap;
    ins_t       cons;
    int         stalls;
    logic [1:0] a;
    logic [1:0] b;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_f, bubble_f, fii_f, stall_i, bubble_i, fii_i, stall_s, bubble_s, fii_s;
  logic [1:0]  fa_f, fb_f, fa_i, fb_i, fa_s, fb_s;
  logic [31:0] cnt_f, cnt_i;
  logic [1:0]  cnt_s;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_f), .bubble(bubble_f), .flush_if_id(fii_f),
    .fwd_a(fa_f), .fwd_b(fb_f), .stall_count(cnt_f));

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(32)) u_ilk (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_i), .bubble(bubble_i), .flush_if_id(fii_i),
    .fwd_a(fa_i), .fwd_b(fb_i), .stall_count(cnt_i));

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_s), .bubble(bubble_s), .flush_if_id(fii_s),
    .fwd_a(fa_s), .fwd_b(fb_s), .stall_count(cnt_s));

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd, input logic rw,
                              input logic ld);
    return '{v: 1'b1, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, rw: rw, ld: ld};
  endfunction

  task automatic drive(input ins_t i, input logic fl);
    id_valid    = i.v;
    id_rs1      = i.rs1;
    id_use_rs1  = i.u1;
    id_rs2      = i.rs2;
    id_use_rs2  = i.u2;
    id_rd       = i.rd;
    id_regwrite = i.rw;
    id_is_load  = i.ld;
    flush       = fl;
  endtask

  function automatic logic cur_stall(input bit fe);
    return fe ? stall_f : stall_i;
  endfunction

  function automatic logic [3:0] cur_fwd(input bit fe);
    return fe ? {fa_f, fb_f} : {fa_i, fb_i};
  endfunction

  function automatic logic [31:0] cur_cnt(input bit fe);
    return fe ? cnt_f : cnt_i;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive('0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Hold the instruction in ID until the selected DUT releases it, bounded.
  task automatic issue(input ins_t i, input bit fe, output int stalls);
    stalls = 0;
    drive(i, 1'b0);
    @(negedge clk);
    while (cur_stall(fe) === 1'b1 && stalls < 10) begin
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // The instruction just accepted is now in EX; compare its selects with the scoreboard.
  task automatic check_fwd(input bit fe, input string name);
    logic [3:0] exp;
    drive(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    exp = sb.pop_front();
    check(name, 32'(cur_fwd(fe)), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ins_t nop, add5, lw5, c_a5, c_b5, c_55, c_50, addi0, c_00, lui6, c_x6;
    vec_t vt[12];
    int   s, s2;

    nop   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    add5  = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    lw5   = mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    c_a5  = mk(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    c_b5  = mk(5'd0, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    c_55  = mk(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    c_50  = mk(5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    addi0 = mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    c_00  = mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    lui6  = mk(5'd5, 1'b0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);
    c_x6  = mk(5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);

    //          fe    prod   gap cons  stalls fwd_a  fwd_b
    vt[0]  = '{1'b1, add5,  0, c_a5, 0, 2'b01, 2'b00};
    vt[1]  = '{1'b1, add5,  1, c_b5, 0, 2'b00, 2'b10};
    vt[2]  = '{1'b1, lw5,   0, c_55, 1, 2'b10, 2'b10};
    vt[3]  = '{1'b0, add5,  0, c_50, 3, 2'b00, 2'b00};
    vt[4]  = '{1'b0, add5,  1, c_50, 2, 2'b00, 2'b00};
    vt[5]  = '{1'b0, add5,  2, c_50, 1, 2'b00, 2'b00};
    vt[6]  = '{1'b1, addi0, 0, c_00, 0, 2'b00, 2'b00};
    vt[7]  = '{1'b0, addi0, 0, c_00, 0, 2'b00, 2'b00};
    vt[8]  = '{1'b1, add5,  2, c_55, 0, 2'b00, 2'b00};
    vt[9]  = '{1'b1, add5,  0, lui6, 0, 2'b00, 2'b00};
    vt[10] = '{1'b1, lw5,   1, c_55, 0, 2'b10, 2'b10};
    vt[11] = '{1'b0, lw5,   0, c_55, 3, 2'b00, 2'b00};

    // Reset state, with and without a concurrent flush.
    reset = 1'b1;
    drive('0, 1'b0);
    #2;
    check("reset fwd ctl", {29'd0, stall_f, bubble_f, fii_f}, 32'd0);
    check("reset ilk ctl", {29'd0, stall_i, bubble_i, fii_i}, 32'd0);
    check("reset fwd sel", {28'd0, fa_f, fb_f, fa_i, fb_i} >> 0, 32'd0);
    check("reset count", cnt_f | cnt_i, 32'd0);
    flush = 1'b1;
    #1;
    check("reset flush ctl", {29'd0, stall_f, bubble_f, fii_f}, 32'd3);
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      do_reset();
      issue(vt[k].prod, vt[k].fe, s);
      for (int g = 0; g < vt[k].gap; g++) issue(nop, vt[k].fe, s);
      sb.push_back({vt[k].a, vt[k].b});
      issue(vt[k].cons, vt[k].fe, s);
      check($sformatf("v%0d stalls", k), 32'(s), 32'(vt[k].stalls));
      check_fwd(vt[k].fe, $sformatf("v%0d fwd", k));
      check($sformatf("v%0d count", k), cur_cnt(vt[k].fe), 32'(vt[k].stalls));
    end

    // Same rd in MEM and WB: the newest (MEM) value is selected.
    do_reset();
    issue(add5, 1'b1, s);
    issue(add5, 1'b1, s);
    sb.push_back(4'b0100);
    issue(c_50, 1'b1, s);
    check_fwd(1'b1, "mem+wb newest");

    // Load-use hit by a flush in the same cycle.
    do_reset();
    issue(lw5, 1'b1, s);
    drive(c_55, 1'b0);
    @(negedge clk);
    check("load-use ctl", {29'd0, stall_f, bubble_f, fii_f}, 32'd6);
    #1;
    flush = 1'b1;
    #1;
    check("flush ctl", {29'd0, stall_f, bubble_f, fii_f}, 32'd3);
    @(posedge clk);
    #1;
    drive(c_x6, 1'b0);
    @(negedge clk);
    check("post-flush stall", {31'd0, stall_f}, 32'd0);
    check("post-flush fwd", {28'd0, fa_f, fb_f}, 32'd0);
    check("post-flush count", cnt_f, 32'd0);
    sb.push_back(4'b0000);
    @(posedge clk);
    #1;
    check_fwd(1'b1, "squashed rd not forwarded");

    // Asynchronous reset in the middle of an interlock stall.
    do_reset();
    issue(add5, 1'b0, s);
    drive(c_50, 1'b0);
    @(negedge clk);
    check("ilk stall", {31'd0, stall_i}, 32'd1);
    @(posedge clk);
    #1;
    check("ilk count mid", cnt_i, 32'd1);
    check("fwd sel pre-reset", {31'd0, (fa_f != 2'b00)}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset ctl", {29'd0, stall_i, bubble_i, fii_i}, 32'd0);
    check("mid reset count", cnt_i, 32'd0);
    check("mid reset fwd", {28'd0, fa_f, fb_f}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive('0, 1'b0);
    @(posedge clk);
    #1;

    // Two back-to-back dependencies: the 2-bit counter saturates at 3.
    do_reset();
    issue(add5, 1'b0, s);
    issue(c_50, 1'b0, s);
    issue(c_x6, 1'b0, s2);
    check("chain stalls", 32'(s + s2), 32'd6);
    check("wide count", cnt_i, 32'd6);
    check("sat count", {30'd0, cnt_s}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised data-hazard controller for the RV32I 5-stage pipeline (IF, ID, EX, MEM, WB). It keeps a shadow pipeline of destination-register records for the EX, MEM and WB stages and detects RAW hazards for the instruction in ID. It drives IF/ID stall, ID/EX bubble and flush, and registered forwarding selects for the EX operand muxes. Mode is selectable: full forwarding, or stall-only interlock. It also exposes a saturating stall-cycle counter for the output_mux debug view.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- FWD_EN, 1, 1 = forwarding from MEM/WB; 0 = interlock-only.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- id_rd  in  REG_AW  ID destination.
- id_regwrite  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  taken branch/jump resolved in EX.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  load zeros/NOP into ID/EX this cycle.
- flush_if_id  out  1  clear IF/ID this cycle.
- fwd_a, fwd_b  out  2  EX operand select: 00 = regfile value, 01 = alu_out_MEM, 10 = wdmux_out_WB.
- stall_count  out  CNT_W  cycles with stall=1, saturating.

## Operation
- State: three records ex_q, mem_q, wb_q, each holding {valid, rd, regwrite, is_load}. A record is a hazard source only if valid && regwrite && rd != 0.
- Every clock edge: wb_q <= mem_q and mem_q <= ex_q. ex_q loads the ID record, or invalid if bubble.
- Match for source s (rs1 or rs2): id_valid && id_use_s && the record is a hazard source && record.rd == id_rs_s.
- FWD_EN=1:
  - stall = match against ex_q with ex_q.is_load (load-use).
  - Forward select for s: 01 if ex_q matches and is not a load. Otherwise 10 if mem_q matches. Otherwise 00. The nearer stage wins.
- FWD_EN=0:
  - stall = any match against ex_q, mem_q or wb_q.
  - fwd_a and fwd_b are held at 00.
  - Regfile writes at the WB edge, so a match on wb_q still stalls.
- bubble = stall || flush.
- flush_if_id = flush.
- Flush priority: when flush=1, stall is forced to 0 (the ID instruction is squashed), ex_q loads invalid, and fwd registers load 00.
- fwd_a/fwd_b registers load the computed selects when not (stall || flush). Otherwise they load 00, matching the bubble entering EX.
- stall_count increments each cycle stall=1 and saturates at all-ones.

## Timing
- stall, bubble and flush_if_id are combinational from ID inputs and state, valid in the same cycle.
- fwd_a/fwd_b are registered and valid in the cycle the instruction occupies EX.
- Load-use costs exactly 1 stall cycle. The consumer then forwards with 10.
- FWD_EN=0 dependency costs:
  - distance 1: 3 stall cycles;
  - distance 2: 2 stall cycles;
  - distance 3: 1 stall cycle.
- Reset (asynchronous, any cycle including mid-stall): all records invalid, fwd_a=fwd_b=00, stall_count=0. stall, bubble and flush_if_id follow the reset state, so they are 0 unless flush=1.
- Same rd in mem_q and wb_q: select 01, the newest value.
- rd=x0 never stalls and never forwards.

## Structure
- Package hazard_pkg:
  - enum fwd_sel_e {FWD_RF, FWD_MEM, FWD_WB};
  - struct hz_rec_t {valid, rd, regwrite, is_load};
  - constant REG_ZERO.
- Sub-module hazard_rec_reg: one async-reset register for an hz_rec_t, with a load-invalid input. Instantiate it three times.
- Hazard-match logic, forwarding-select logic and the counter live in hazard_unit.

## Test plan
- FWD_EN=1, add x5,x1,x2 then add x6,x5,x3 -> no stall; fwd_a=01 in the consumer's EX cycle.
- FWD_EN=1, add x5, then nop, then sub x7,x0,x5 -> fwd_b=10; fwd_a=00.
- FWD_EN=1, lw x5,0(x1) then add x6,x5,x5 -> stall=1 and bubble=1 for 1 cycle; then fwd_a=fwd_b=10; stall_count=1.
- FWD_EN=0, add x5 then add x6,x5,x0 -> stall for 3 cycles; fwd stays 00; stall_count=3.
- addi x0,x0,1 then add x6,x0,x0 -> no stall, fwd 00. Writes to x5 in both MEM and WB, followed by a use of x5 -> select 01.
- Load-use with flush=1 in the same cycle -> stall=0, bubble=1, flush_if_id=1; next cycle ex_q invalid and fwd=00. Assert reset mid-stall -> all outputs return to reset values immediately.
